// File: rtl/alu_result_bcd.sv
// -----------------------------------------------------------------------------
// alu_result_bcd
//
// Converts the registered binary ALU result to packed BCD for the seven-segment
// display driver. It uses a sequential double-dabble: one correct-and-shift step
// per clock. Both sides use a valid/ready handshake. A leading-zero blanking mask
// lets the display driver suppress insignificant digits.
//
// Parameters
//   IN_WIDTH  width of the unsigned binary input (2*WIDTH of the ALU)
//   DIGITS    number of BCD output digits; 10^DIGITS must exceed 2^IN_WIDTH-1
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_data    unsigned binary value to convert
//   in_valid   in_data is valid this cycle
//   in_ready   block can accept a value (IDLE only)
//   bcd        packed BCD result, digit 0 (units) in bcd[3:0]
//   digit_nz   per-digit significance mask, bit 0 always set with a result
//   out_valid  bcd/digit_nz hold a completed conversion
//   out_ready  consumer accepts the result
//   busy       conversion in progress (SHIFT)
// -----------------------------------------------------------------------------
module alu_result_bcd #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_nz,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

    // 10^DIGITS must be able to hold the largest input. Otherwise the 4-bit
    // digit corrections could overflow without anyone noticing.
    function automatic bit digits_sufficient();
        logic [127:0] pow10;
        logic [127:0] max_in;
        pow10  = 128'd1;
        for (int i = 0; i < DIGITS; i++) begin
            pow10 = pow10 * 128'd10;
        end
        max_in = (128'd1 << IN_WIDTH) - 128'd1;
        return pow10 > max_in;
    endfunction

    generate
        if (!digits_sufficient()) begin : g_bad_digits
            $fatal(1, "alu_result_bcd: DIGITS too small for IN_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_reg,    state_next;
    logic [IN_WIDTH-1:0]    bin_reg,      bin_next;
    logic [BCD_W-1:0]       scratch_reg,  scratch_next;
    logic [CNT_W-1:0]       cnt_reg,      cnt_next;
    logic [BCD_W-1:0]       bcd_reg,      bcd_next;
    logic [DIGITS-1:0]      digit_nz_reg, digit_nz_next;

    // Datapath for one double-dabble step.
    logic [BCD_W-1:0]           scratch_adj;
    logic [BCD_W+IN_WIDTH-1:0]  combo_shl;
    logic [BCD_W-1:0]           scratch_shl;
    logic [IN_WIDTH-1:0]        bin_shl;
    logic [DIGITS-1:0]          nz_shl;
    logic                       last_shift;

    // Every digit >= 5 gets +3 in parallel. The add is 4 bits with no carry
    // out, because a corrected digit is at most 12.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            logic [3:0] digit;
            assign digit = scratch_reg[4*gi +: 4];
            assign scratch_adj[4*gi +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
        end
    endgenerate

    // {scratch, binary} shifts left as one vector. The binary MSB feeds the units digit.
    assign combo_shl   = {scratch_adj, bin_reg} << 1;
    assign scratch_shl = combo_shl[BCD_W+IN_WIDTH-1:IN_WIDTH];
    assign bin_shl     = combo_shl[IN_WIDTH-1:0];

    // Digit i is significant if it or any higher digit is nonzero. The units
    // digit is always shown, so zero displays as a single "0".
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nz
            if (gi == 0) begin : g_units
                assign nz_shl[gi] = 1'b1;
            end else begin : g_upper
                assign nz_shl[gi] = |scratch_shl[BCD_W-1:4*gi];
            end
        end
    endgenerate

    assign last_shift = (cnt_reg == CNT_W'(IN_WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            bin_reg      <= '0;
            scratch_reg  <= '0;
            cnt_reg      <= '0;
            bcd_reg      <= '0;
            digit_nz_reg <= '0;
        end else begin
            state_reg    <= state_next;
            bin_reg      <= bin_next;
            scratch_reg  <= scratch_next;
            cnt_reg      <= cnt_next;
            bcd_reg      <= bcd_next;
            digit_nz_reg <= digit_nz_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bin_next      = bin_reg;
        scratch_next  = scratch_reg;
        cnt_next      = cnt_reg;
        bcd_next      = bcd_reg;
        digit_nz_next = digit_nz_reg;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    bin_next     = in_data;
                    scratch_next = '0;
                    cnt_next     = '0;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bin_next     = bin_shl;
                scratch_next = scratch_shl;
                cnt_next     = cnt_reg + CNT_W'(1);
                if (last_shift) begin
                    bcd_next      = scratch_shl;
                    digit_nz_next = nz_shl;
                    state_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                // The result is held for as long as the consumer stalls.
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign busy      = (state_reg == ST_SHIFT);
    assign out_valid = (state_reg == ST_DONE);
    assign bcd       = bcd_reg;
    assign digit_nz  = digit_nz_reg;

endmodule

// File: tb/tb_alu_result_bcd.sv
module tb_alu_result_bcd;

    localparam int IN_WIDTH = 8;
    localparam int DIGITS   = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [IN_WIDTH-1:0]   in_data = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     digit_nz;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic                  busy;

    int n_vectors     = 0;
    int n_miscompares = 0;

    alu_result_bcd #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd       (bcd),
        .digit_nz  (digit_nz),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division.
    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int rem;
        r   = '0;
        rem = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

    // Reference: digit i is significant when v >= 10^i; the units digit is always shown.
    function automatic logic [DIGITS-1:0] ref_nz(input int v);
        logic [DIGITS-1:0] r;
        int p;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[i] = (i == 0) || (v >= p);
            p    = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a value for one cycle, time the conversion, stall the consumer, then drain.
    task automatic convert(input int v, input int stall);
        int edges;
        int busy_cnt;
        logic [4*DIGITS-1:0] held;
        in_data  = IN_WIDTH'(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("accept_in_ready", 32'(in_ready), 32'd0);
        edges    = 0;
        busy_cnt = 0;
        while (!out_valid && edges < 100) begin
            if (busy) busy_cnt++;
            tick();
            edges++;
        end
        check("latency", edges, IN_WIDTH);
        check("busy_cycles", busy_cnt, IN_WIDTH);
        check("bcd", 32'(bcd), 32'(ref_bcd(v)));
        check("digit_nz", 32'(digit_nz), 32'(ref_nz(v)));
        held = bcd;
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_bcd", 32'(bcd), 32'(held));
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
        check("drain_bcd_kept", 32'(bcd), 32'(ref_bcd(v)));
        $display("xfer in=%0d bcd=%03h nz=%b latency=%0d stall=%0d", v, bcd, digit_nz, edges, stall);
    endtask

    initial begin
        int e;

        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_digit_nz", 32'(digit_nz), 32'd0);

        // Maximum value, then the directed digit patterns.
        convert(255, 0);
        convert(0, 0);
        convert(7, 0);
        convert(100, 0);
        convert(42, 0);

        // Long backpressure.
        convert(137, 20);

        // Input changes while busy are ignored; re-presented value is taken on the first IDLE edge.
        out_ready = 1'b1;
        in_data   = 8'd200;
        in_valid  = 1'b1;
        tick();
        in_data = 8'd13;
        e = 0;
        while (!out_valid && e < 100) begin
            tick();
            e++;
        end
        check("busy_in_first_latency", e, IN_WIDTH);
        check("busy_in_first_bcd", 32'(bcd), 32'(ref_bcd(200)));
        e = 0;
        do begin
            tick();
            e++;
        end while (!out_valid && e < 100);
        in_valid = 1'b0;
        check("busy_in_second_gap", e, IN_WIDTH + 2);
        check("busy_in_second_bcd", 32'(bcd), 32'(ref_bcd(13)));
        check("busy_in_second_nz", 32'(digit_nz), 32'(ref_nz(13)));
        $display("xfer in=200,13 bcd=%03h nz=%b gap=%0d", bcd, digit_nz, e);
        tick();
        out_ready = 1'b0;
        check("busy_in_idle", 32'(in_ready), 32'd1);

        // Asynchronous reset during SHIFT, between clock edges.
        in_data  = 8'd99;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("pre_abort_busy", 32'(busy), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_digit_nz", 32'(digit_nz), 32'd0);
        $display("xfer in=99 aborted by reset");
        tick();
        rst = 1'b0;
        tick();
        check("post_abort_idle", 32'(busy), 32'd0);
        convert(99, 1);

        // Full sweep with random consumer stalls.
        for (int v = 0; v < (1 << IN_WIDTH); v++) begin
            convert(v, int'($urandom_range(0, 3)));
        end

        // A few random values with random stalls.
        for (int k = 0; k < 16; k++) begin
            convert(int'($urandom_range(0, (1 << IN_WIDTH) - 1)), int'($urandom_range(0, 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
